// File: rtl/wb_commit_multi.sv
// rtl/wb_commit_multi.sv - N-lane writeback/commit stage with in-order kill, RF write ports and trace FIFO
module wb_commit_multi #(
    parameter int LANES     = 2,
    parameter int XLEN      = 32,
    parameter int DBG_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_flush,
    output logic                  w_allowin,
    input  logic                  mw_valid,
    input  logic [LANES-1:0]      mw_lane_valid,
    input  logic [LANES*32-1:0]   mw_pc,
    input  logic [LANES*XLEN-1:0] mw_result,
    input  logic [LANES-1:0]      mw_gr_we,
    input  logic [LANES*5-1:0]    mw_dest,
    input  logic [LANES-1:0]      mw_ex,
    input  logic [LANES*9-1:0]    mw_ecode,
    input  logic [LANES*32-1:0]   mw_vaddr,
    output logic [LANES-1:0]      rf_we,
    output logic [LANES*5-1:0]    rf_waddr,
    output logic [LANES*XLEN-1:0] rf_wdata,
    output logic                  ex_valid,
    output logic [72:0]           ex_info,
    output logic [2:0]            commit_cnt,
    output logic                  dbg_fifo_full,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_we,
    output logic [4:0]            debug_wb_rf_wnum,
    output logic [31:0]           debug_wb_rf_wdata
);
    localparam int AW = $clog2(DBG_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DBG_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } trace_t;

    logic                  w_valid_q, w_valid_d;
    logic [LANES-1:0]      lane_valid_q, lane_valid_d;
    logic [LANES*32-1:0]   pc_q, pc_d;
    logic [LANES*XLEN-1:0] result_q, result_d;
    logic [LANES-1:0]      gr_we_q, gr_we_d;
    logic [LANES*5-1:0]    dest_q, dest_d;
    logic [LANES-1:0]      ex_q, ex_d;
    logic [LANES*9-1:0]    ecode_q, ecode_d;
    logic [LANES*32-1:0]   vaddr_q, vaddr_d;

    trace_t          fifo_mem_q [DBG_DEPTH];
    trace_t          fifo_mem_d [DBG_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, widx;
    logic [CW-1:0]   count_q, count_d, free_slots;

    logic [LANES-1:0] live, commit, wr;
    logic [2:0]       push_n;
    logic             has_ex, w_ready_go, go, pop;
    logic [72:0]      ex_sel;
    trace_t           head;

    // Walk lanes oldest-first; everything after the first excepting lane is killed.
    always_comb begin
        has_ex = 1'b0;
        live   = '0;
        push_n = '0;
        ex_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_valid_q[i] && !has_ex) begin
                live[i] = 1'b1;
                if (ex_q[i]) begin
                    has_ex = 1'b1;
                    ex_sel = {ecode_q[i*9 +: 9], pc_q[i*32 +: 32], vaddr_q[i*32 +: 32]};
                end else begin
                    push_n = push_n + 3'd1;
                end
            end
        end
    end

    assign free_slots = DEPTH_C - count_q;
    assign w_ready_go = free_slots >= CW'(push_n);
    assign w_allowin  = !w_valid_q || w_ready_go;
    assign go         = w_valid_q && w_ready_go;
    assign commit     = {LANES{go}} & live & ~ex_q;
    assign commit_cnt = go ? push_n : 3'd0;
    assign ex_valid   = go && has_ex;
    assign ex_info    = ex_valid ? ex_sel : '0;

    // The youngest committing writer of a register wins the RF port.
    always_comb begin
        rf_we    = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            wr[i] = commit[i] && gr_we_q[i] && (dest_q[i*5 +: 5] != 5'd0);
        end
        for (int i = 0; i < LANES; i++) begin
            rf_we[i] = wr[i];
            for (int j = i + 1; j < LANES; j++) begin
                if (wr[j] && dest_q[j*5 +: 5] == dest_q[i*5 +: 5]) rf_we[i] = 1'b0;
            end
            if (rf_we[i]) begin
                rf_waddr[i*5 +: 5]       = dest_q[i*5 +: 5];
                rf_wdata[i*XLEN +: XLEN] = result_q[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_valid_d    = w_valid_q;
        lane_valid_d = lane_valid_q;
        pc_d         = pc_q;
        result_d     = result_q;
        gr_we_d      = gr_we_q;
        dest_d       = dest_q;
        ex_d         = ex_q;
        ecode_d      = ecode_q;
        vaddr_d      = vaddr_q;
        if (ex_flush) begin
            w_valid_d    = 1'b0;
            lane_valid_d = '0;
            pc_d         = '0;
            result_d     = '0;
            gr_we_d      = '0;
            dest_d       = '0;
            ex_d         = '0;
            ecode_d      = '0;
            vaddr_d      = '0;
        end else if (w_allowin) begin
            w_valid_d = mw_valid;
            if (mw_valid) begin
                lane_valid_d = mw_lane_valid;
                pc_d         = mw_pc;
                result_d     = mw_result;
                gr_we_d      = mw_gr_we;
                dest_d       = mw_dest;
                ex_d         = mw_ex;
                ecode_d      = mw_ecode;
                vaddr_d      = mw_vaddr;
            end
        end
    end

    // Trace entries keep the unmasked write strobe so shadowed writes stay visible.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        widx       = wptr_q;
        for (int i = 0; i < LANES; i++) begin
            if (commit[i]) begin
                fifo_mem_d[widx] = '{pc: pc_q[i*32 +: 32], we: wr[i], dest: dest_q[i*5 +: 5],
                                     data: result_q[i*XLEN +: 32]};
                widx = widx + AW'(1);
            end
        end
        wptr_d  = widx;
        pop     = count_q != '0;
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(commit_cnt) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_valid_q    <= 1'b0;
            lane_valid_q <= '0;
            pc_q         <= '0;
            result_q     <= '0;
            gr_we_q      <= '0;
            dest_q       <= '0;
            ex_q         <= '0;
            ecode_q      <= '0;
            vaddr_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            for (int i = 0; i < DBG_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            w_valid_q    <= w_valid_d;
            lane_valid_q <= lane_valid_d;
            pc_q         <= pc_d;
            result_q     <= result_d;
            gr_we_q      <= gr_we_d;
            dest_q       <= dest_d;
            ex_q         <= ex_d;
            ecode_q      <= ecode_d;
            vaddr_q      <= vaddr_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            fifo_mem_q   <= fifo_mem_d;
        end
    end

    assign head              = fifo_mem_q[rptr_q];
    assign dbg_fifo_full     = count_q == DEPTH_C;
    assign debug_wb_pc       = pop ? head.pc : '0;
    assign debug_wb_rf_we    = pop ? {4{head.we}} : '0;
    assign debug_wb_rf_wnum  = pop ? head.dest : '0;
    assign debug_wb_rf_wdata = pop ? head.data : '0;
endmodule

// File: tb/tb_wb_commit_multi.sv
// tb/tb_wb_commit_multi.sv - directed scoreboard bench for wb_commit_multi
module tb_wb_commit_multi;
    localparam int L = 2;
    localparam int D = 8;

    logic          clk, rst, ex_flush, w_allowin, mw_valid;
    logic [L-1:0]  mw_lane_valid, mw_gr_we, mw_ex, rf_we;
    logic [L*32-1:0] mw_pc, mw_result, mw_vaddr, rf_wdata;
    logic [L*5-1:0]  mw_dest, rf_waddr;
    logic [L*9-1:0]  mw_ecode;
    logic          ex_valid, dbg_fifo_full;
    logic [72:0]   ex_info;
    logic [2:0]    commit_cnt;
    logic [31:0]   debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]    debug_wb_rf_we;
    logic [4:0]    debug_wb_rf_wnum;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } trace_t;

    trace_t      exp_q[$];
    logic [31:0] rf_model [32];
    int          n_assert = 0;
    int          n_fail = 0;
    bit          saw_stall = 0;

    wb_commit_multi #(.LANES(L), .XLEN(32), .DBG_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ex_flush(ex_flush), .w_allowin(w_allowin),
        .mw_valid(mw_valid), .mw_lane_valid(mw_lane_valid), .mw_pc(mw_pc),
        .mw_result(mw_result), .mw_gr_we(mw_gr_we), .mw_dest(mw_dest),
        .mw_ex(mw_ex), .mw_ecode(mw_ecode), .mw_vaddr(mw_vaddr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ex_valid(ex_valid), .ex_info(ex_info), .commit_cnt(commit_cnt),
        .dbg_fifo_full(dbg_fifo_full), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] res,
                            input logic we, input logic [4:0] dest, input logic ex,
                            input logic [8:0] ecode, input logic [31:0] vaddr);
        mw_lane_valid[i]     = 1'b1;
        mw_pc[i*32 +: 32]    = pc;
        mw_result[i*32 +: 32] = res;
        mw_gr_we[i]          = we;
        mw_dest[i*5 +: 5]    = dest;
        mw_ex[i]             = ex;
        mw_ecode[i*9 +: 9]   = ecode;
        mw_vaddr[i*32 +: 32] = vaddr;
    endtask

    task automatic expect_trace(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                                input logic [31:0] data);
        trace_t t;
        t.pc = pc; t.we = we; t.dest = dest; t.data = data;
        exp_q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
    endtask

    // Streams 2-lane bundles while tracking the expected FIFO occupancy cycle by cycle.
    task automatic stream(input int nb, input int stop_at);
        int k = 0, mcount = 0, cyc = 0;
        bit mwv = 0, exp_allow, go;
        while (k < nb && cyc < 400 && !(stop_at >= 0 && mcount == stop_at)) begin
            for (int i = 0; i < L; i++)
                set_lane(i, 32'h2000 + k*8 + i*4, 32'h5000 + k*2 + i, 1'b1, 5'(10 + i), 1'b0, 9'd0, 32'd0);
            mw_valid = 1'b1;
            exp_allow = !mwv || (D - mcount >= 2);
            check("stream_allowin", 128'(w_allowin), 128'(exp_allow));
            if (!exp_allow) saw_stall = 1;
            go = mwv && (D - mcount >= 2);
            mcount = mcount + (go ? 2 : 0) - (mcount != 0 ? 1 : 0);
            if (exp_allow) begin
                mwv = 1;
                for (int i = 0; i < L; i++)
                    expect_trace(32'h2000 + k*8 + i*4, 1'b1, 5'(10 + i), 32'h5000 + k*2 + i);
                k++;
            end
            tick();
            cyc++;
        end
        mw_valid = 1'b0;
        check("stream_no_timeout", 128'(cyc < 400), 128'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < L; i++)
                if (rf_we[i]) rf_model[rf_waddr[i*5 +: 5]] = rf_wdata[i*32 +: 32];
            if (debug_wb_pc != 32'd0) begin
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL trace_unexpected observed pc=%0h expected none", debug_wb_pc);
                end else begin
                    trace_t e;
                    e = exp_q.pop_front();
                    check("trace_entry", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata},
                          {e.pc, {4{e.we}}, e.dest, e.data});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; ex_flush = 1'b0; mw_valid = 1'b0;
        mw_lane_valid = '0; mw_pc = '0; mw_result = '0; mw_gr_we = '0;
        mw_dest = '0; mw_ex = '0; mw_ecode = '0; mw_vaddr = '0;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        #12;
        check("reset_allowin", 128'(w_allowin), 128'd1);
        check("reset_outputs", {rf_we, ex_valid, ex_info, commit_cnt, dbg_fifo_full},
              128'd0);
        check("reset_debug", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 128'd0);
        rst = 1'b0;
        tick();

        // two clean lanes
        set_lane(0, 32'h1000, 32'hA0, 1'b1, 5'd3, 1'b0, 9'd0, 32'd0);
        set_lane(1, 32'h1004, 32'hA1, 1'b1, 5'd4, 1'b0, 9'd0, 32'd0);
        mw_valid = 1'b1;
        expect_trace(32'h1000, 1'b1, 5'd3, 32'hA0);
        expect_trace(32'h1004, 1'b1, 5'd4, 32'hA1);
        tick();
        mw_valid = 1'b0;
        check("t1_rf_we", 128'(rf_we), 128'b11);
        check("t1_commit_cnt", 128'(commit_cnt), 128'd2);
        check("t1_waddr", 128'(rf_waddr), {118'd0, 5'd4, 5'd3});
        check("t1_wdata", 128'(rf_wdata), {64'd0, 32'hA1, 32'hA0});
        check("t1_ex_valid", 128'(ex_valid), 128'd0);
        tick();
        check("t1_no_repeat", 128'(rf_we), 128'd0);
        drain();

        // lane0 excepts: everything killed
        set_lane(0, 32'h1100, 32'hB0, 1'b1, 5'd6, 1'b1, 9'h016, 32'hDEAD0000);
        set_lane(1, 32'h1104, 32'hB1, 1'b1, 5'd8, 1'b0, 9'd0, 32'd0);
        mw_valid = 1'b1;
        tick();
        mw_valid = 1'b0;
        check("t2_rf_we", 128'(rf_we), 128'd0);
        check("t2_ex_valid", 128'(ex_valid), 128'd1);
        check("t2_ex_info", 128'(ex_info), 128'({9'h016, 32'h1100, 32'hDEAD0000}));
        check("t2_commit_cnt", 128'(commit_cnt), 128'd0);
        tick();
        check("t2_ex_pulse", 128'(ex_valid), 128'd0);

        // lane1 excepts, lane0 commits; then flush discards the next bundle
        set_lane(0, 32'h1200, 32'h55, 1'b1, 5'd5, 1'b0, 9'd0, 32'd0);
        set_lane(1, 32'h1204, 32'h66, 1'b1, 5'd9, 1'b1, 9'h007, 32'hBEEF);
        mw_valid = 1'b1;
        expect_trace(32'h1200, 1'b1, 5'd5, 32'h55);
        tick();
        check("t3_rf_we", 128'(rf_we), 128'b01);
        check("t3_ex_valid", 128'(ex_valid), 128'd1);
        check("t3_ex_info", 128'(ex_info), 128'({9'h007, 32'h1204, 32'hBEEF}));
        check("t3_commit_cnt", 128'(commit_cnt), 128'd1);
        set_lane(0, 32'h1300, 32'h77, 1'b1, 5'd9, 1'b0, 9'd0, 32'd0);
        set_lane(1, 32'h1304, 32'h78, 1'b1, 5'd10, 1'b0, 9'd0, 32'd0);
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        mw_valid = 1'b0;
        check("t3_flush_rf_we", 128'(rf_we), 128'd0);
        check("t3_flush_commit", 128'(commit_cnt), 128'd0);
        check("t3_flush_ex", 128'(ex_valid), 128'd0);
        drain();

        // same-dest writers: youngest wins the port, both traced
        set_lane(0, 32'h1400, 32'h11, 1'b1, 5'd7, 1'b0, 9'd0, 32'd0);
        set_lane(1, 32'h1404, 32'h22, 1'b1, 5'd7, 1'b0, 9'd0, 32'd0);
        mw_valid = 1'b1;
        expect_trace(32'h1400, 1'b1, 5'd7, 32'h11);
        expect_trace(32'h1404, 1'b1, 5'd7, 32'h22);
        tick();
        mw_valid = 1'b0;
        check("t4_rf_we", 128'(rf_we), 128'b10);
        check("t4_waddr1", 128'(rf_waddr[9:5]), 128'd7);
        check("t4_wdata1", 128'(rf_wdata[63:32]), 128'h22);
        check("t4_commit_cnt", 128'(commit_cnt), 128'd2);
        drain();
        check("t4_rf_r7", 128'(rf_model[7]), 128'h22);

        // back-to-back bundles through the 8-deep FIFO, several wraps
        stream(16, -1);
        check("t5_saw_stall", 128'(saw_stall), 128'd1);
        drain();

        // async reset mid-operation drops all trace entries
        stream(100, 5);
        mw_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("t6_debug_zero", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 128'd0);
        check("t6_outputs_zero", {rf_we, ex_valid, commit_cnt, dbg_fifo_full}, 128'd0);
        check("t6_allowin", 128'(w_allowin), 128'd1);
        exp_q.delete();
        mw_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("t6_fifo_empty", 128'(debug_wb_pc), 128'd0);
        check("t6_rf_idle", 128'(rf_we), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
